// File: rtl/rf_write_scheduler_pkg.sv
// Shared constants for the register-file write scheduler:
// requester indices, requester count and regfile address width.
package rf_write_scheduler_pkg;

    localparam int NREQ = 3;
    localparam int AW   = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_LINK = 2;

    typedef logic [1:0]    req_idx_t;
    typedef logic [AW-1:0] rf_addr_t;

    // Round-robin successor of a granted index.
    function automatic req_idx_t next_ptr(input req_idx_t g);
        return (g == req_idx_t'(REQ_LINK)) ? req_idx_t'(REQ_ALU) : g + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: scans from ptr_i upward (mod 3)
// and grants the first valid requester when enabled.
module rr_arbiter3
    import rf_write_scheduler_pkg::*;
(
    input  logic [NREQ-1:0] valid_i,
    input  req_idx_t        ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output req_idx_t        idx_o,
    output logic            any_o
);

    logic [2:0] sum;
    req_idx_t   cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        if (enable_i) begin
            for (int k = 0; k < NREQ; k++) begin
                sum  = {1'b0, ptr_i} + 3'(k);
                cand = (sum >= 3'd3) ? req_idx_t'(sum - 3'd3) : req_idx_t'(sum);
                if (!any_o && valid_i[cand]) begin
                    any_o         = 1'b1;
                    idx_o         = cand;
                    grant_o[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single regfile write port between ALU, LOAD and LINK
// writeback, drives a registered write and flags read-after-write hazards.
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [AW-1:0]     adr_src1,
    input  logic [AW-1:0]     adr_src2,
    output logic              hz_src1,
    output logic              hz_src2,
    output logic [W-1:0]      DATA_in,
    output logic [AW-1:0]     adr_dst,
    output logic              write_enable
);

    req_idx_t      rr_ptr_q, rr_ptr_d;
    logic          we_q, we_d;
    rf_addr_t      adr_q, adr_d;
    logic [W-1:0]  data_q, data_d;
    req_idx_t      gnt_idx;
    logic          gnt_any;

    // Ready is forced low while reset is asserted.
    rr_arbiter3 u_arb (
        .valid_i  (req_valid),
        .ptr_i    (rr_ptr_q),
        .enable_i (~hold & reset),
        .grant_o  (req_ready),
        .idx_o    (gnt_idx),
        .any_o    (gnt_any)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        adr_d    = adr_q;
        data_d   = data_q;
        if (gnt_any) begin
            rr_ptr_d = next_ptr(gnt_idx);
            we_d     = 1'b1;
            adr_d    = req_addr[gnt_idx*AW +: AW];
            data_d   = req_data[gnt_idx*W +: W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            data_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
        end
    end

    assign write_enable = we_q;
    assign adr_dst      = adr_q;
    assign DATA_in      = data_q;

    always_comb begin
        hz_src1 = we_q & (adr_q == adr_src1);
        hz_src2 = we_q & (adr_q == adr_src2);
        for (int i = 0; i < NREQ; i++) begin
            hz_src1 |= req_valid[i] & (req_addr[i*AW +: AW] == adr_src1);
            hz_src2 |= req_valid[i] & (req_addr[i*AW +: AW] == adr_src2);
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler with a small regfile model.
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next.
module tb_rf_write_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic [2:0] req_valid;
    logic [8:0] req_addr;
    logic [23:0] req_data;
    logic [2:0] req_ready;
    logic [2:0] adr_src1, adr_src2;
    logic       hz_src1, hz_src2;
    logic [7:0] DATA_in;
    logic [2:0] adr_dst;
    logic       write_enable;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rf [8];

    always #5 clk = ~clk;

    always @(posedge clk) if (write_enable) rf[adr_dst] <= DATA_in;

    rf_write_scheduler #(.W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .adr_src1     (adr_src1),
        .adr_src2     (adr_src2),
        .hz_src1      (hz_src1),
        .hz_src2      (hz_src2),
        .DATA_in      (DATA_in),
        .adr_dst      (adr_dst),
        .write_enable (write_enable)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        check("we", write_enable, 1);
        check("adr", adr_dst, a);
        check("data", DATA_in, d);
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0; req_valid = 3'b001;
        req_addr = '0; req_data = '0; adr_src1 = '0; adr_src2 = '0;
        #12;
        check("rst_we", write_enable, 0);
        check("rst_adr", adr_dst, 0);
        check("rst_data", DATA_in, 0);
        check("rst_ready", req_ready, 0);

        // 1: async reset kills a pending write, then a single write
        reset = 1'b1; set_req(0, 3'd6, 8'h33);
        #1 check("t1_ready_pre", req_ready, 3'b001);
        tick(); req_valid = 3'b000;
        wr(3'd6, 8'h33);
        reset = 1'b0;
        #1 check("t1_async_we", write_enable, 0);
        reset = 1'b1;
        req_valid = 3'b001; set_req(0, 3'd2, 8'h5A);
        #1 check("t1_ready", req_ready, 3'b001);
        tick(); req_valid = 3'b000;
        wr(3'd2, 8'h5A);

        // 2: all three from reset
        reset = 1'b0; #1 reset = 1'b1;
        set_req(0, 3'd1, 8'hA1); set_req(1, 3'd2, 8'hB2); set_req(2, 3'd3, 8'hC3);
        req_valid = 3'b111;
        #1 check("t2_g0", req_ready, 3'b001);
        tick(); req_valid = 3'b110;
        wr(3'd1, 8'hA1);
        #1 check("t2_g1", req_ready, 3'b010);
        tick(); req_valid = 3'b100;
        wr(3'd2, 8'hB2);
        #1 check("t2_g2", req_ready, 3'b100);
        tick(); req_valid = 3'b000;
        wr(3'd3, 8'hC3);
        // pointer back at 0: {0,2} valid must pick 0
        set_req(0, 3'd0, 8'h10); set_req(2, 3'd7, 8'h70);
        req_valid = 3'b101;
        #1 check("t2_ptr0", req_ready, 3'b001);
        tick(); req_valid = 3'b100;
        wr(3'd0, 8'h10);
        #1 check("t2_next", req_ready, 3'b100);
        tick(); req_valid = 3'b000;
        wr(3'd7, 8'h70);

        // 3: after req1 grant, req2 beats req0
        set_req(1, 3'd6, 8'h66); req_valid = 3'b010;
        #1 check("t3_g1", req_ready, 3'b010);
        tick();
        wr(3'd6, 8'h66);
        set_req(0, 3'd1, 8'h01); set_req(2, 3'd5, 8'h55); req_valid = 3'b101;
        #1 check("t3_g2", req_ready, 3'b100);
        tick(); req_valid = 3'b001;
        wr(3'd5, 8'h55);
        #1 check("t3_g0", req_ready, 3'b001);
        tick(); req_valid = 3'b000;
        wr(3'd1, 8'h01);

        // 4: hold gates acceptance only
        hold = 1'b1; set_req(1, 3'd3, 8'h77); req_valid = 3'b010;
        #1 check("t4_ready_h1", req_ready, 0);
        check("t4_we_h1", write_enable, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_ready_h", req_ready, 0);
            check("t4_we_h", write_enable, 0);
        end
        hold = 1'b0;
        #1 check("t4_ready_rel", req_ready, 3'b010);
        tick(); req_valid = 3'b000;
        wr(3'd3, 8'h77);

        // 5: same destination from two requesters
        reset = 1'b0; #1 reset = 1'b1;
        set_req(0, 3'd5, 8'h11); set_req(2, 3'd5, 8'h22); req_valid = 3'b101;
        #1 check("t5_g0", req_ready, 3'b001);
        tick(); req_valid = 3'b100;
        wr(3'd5, 8'h11);
        #1 check("t5_g2", req_ready, 3'b100);
        tick(); req_valid = 3'b000;
        wr(3'd5, 8'h22);
        tick();
        check("t5_we_off", write_enable, 0);
        check("t5_data_keep", DATA_in, 8'h22);
        check("t5_r5", rf[5], 8'h22);

        // 6: hazard tracking through the write cycle
        adr_src1 = 3'd4; adr_src2 = 3'd3;
        #1 check("t6_hz1_idle", hz_src1, 0);
        set_req(2, 3'd4, 8'h44); req_valid = 3'b100;
        #1 check("t6_hz1_req", hz_src1, 1);
        check("t6_hz2_req", hz_src2, 0);
        tick(); req_valid = 3'b000;
        check("t6_hz1_wr", hz_src1, 1);
        check("t6_hz2_wr", hz_src2, 0);
        wr(3'd4, 8'h44);
        tick();
        check("t6_hz1_done", hz_src1, 0);
        check("t6_hz2_done", hz_src2, 0);
        hold = 1'b1; req_valid = 3'b100;
        #1 check("t6_hz1_hold", hz_src1, 1);
        hold = 1'b0; req_valid = 3'b000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
